// File: rtl/rr_resource_arbiter8_pkg.sv
// Shared types, sizes and helpers for the 8-way resource arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        COOLDOWN = 2'd2
    } arb_state_e;

    // Rotate right by amt: result bit i takes vec bit (i + amt) mod NUM_REQ.
    function automatic logic [NUM_REQ-1:0] rotate_right(
        input logic [NUM_REQ-1:0] vec,
        input logic [IDX_W-1:0]   amt
    );
        logic [NUM_REQ-1:0] res;
        logic [IDX_W-1:0]   src;
        res = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            src    = IDX_W'(i) + amt;
            res[i] = vec[src];
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_resource_arbiter8_prio_enc8_lowfirst.sv
// Combinational 8-input priority encoder; the lowest set bit wins.
module prio_enc8_lowfirst
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    output logic [IDX_W-1:0]   idx_c,
    output logic               found_c
);

    always_comb begin
        idx_c   = '0;
        found_c = 1'b0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_c   = IDX_W'(i);
                found_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter8.sv
// 8-requester single-owner arbiter with hold timeout and one-cycle cooldown.
// Round-robin selection is built when RR_RESOURCE_ARBITER8_ROUND_ROBIN_EN is defined.
module rr_resource_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               notEN,
    input  logic [NUM_REQ-1:0] Request,
    input  logic               Release,
    output logic [NUM_REQ-1:0] Grant,
    output logic [IDX_W-1:0]   GrantIndex,
    output logic               GrantValid,
    output logic               Timeout
);

    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] enc_in;
    logic [IDX_W-1:0]   enc_idx_c;
    logic               enc_found_c;
    logic [IDX_W-1:0]   sel_idx;
    logic               owner_drop;
    logic               to_hit;

    prio_enc8_lowfirst u_enc (
        .req_i   (enc_in),
        .idx_c   (enc_idx_c),
        .found_c (enc_found_c)
    );

`ifdef RR_RESOURCE_ARBITER8_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] rot_amt;

    // Search starts just after the previous owner; map the encoded index back.
    always_comb begin
        rot_amt = last_q + IDX_W'(1);
        enc_in  = rotate_right(Request, rot_amt);
        sel_idx = enc_idx_c + rot_amt;
    end
`else
    always_comb begin
        enc_in  = Request;
        sel_idx = enc_idx_c;
    end
`endif

    always_comb begin
        owner_drop = !Request[idx_q];
        to_hit     = TO_EN && (cnt_q == TO_LAST);
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
`ifdef RR_RESOURCE_ARBITER8_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (!notEN && enc_found_c) begin
                    state_d = GRANT;
                    grant_d = NUM_REQ'(1) << sel_idx;
                    idx_d   = sel_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
`ifdef RR_RESOURCE_ARBITER8_ROUND_ROBIN_EN
                    last_d  = sel_idx;
`endif
                end
            end
            GRANT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                if (owner_drop || Release || to_hit) begin
                    state_d   = COOLDOWN;
                    grant_d   = '0;
                    idx_d     = '0;
                    valid_d   = 1'b0;
                    cnt_d     = '0;
                    // Flag only revocations the owner did not ask for.
                    timeout_d = to_hit && !owner_drop && !Release;
                end
            end
            COOLDOWN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
`ifdef RR_RESOURCE_ARBITER8_ROUND_ROBIN_EN
            last_q    <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
`ifdef RR_RESOURCE_ARBITER8_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign Grant      = grant_q;
    assign GrantIndex = idx_q;
    assign GrantValid = valid_q;
    assign Timeout    = timeout_q;

endmodule

// File: tb/tb_rr_resource_arbiter8.sv
// Bench for rr_resource_arbiter8: per-cycle ownership model plus directed literal checks.
module tb_rr_resource_arbiter8;

    localparam int TO = 4;
`ifdef RR_RESOURCE_ARBITER8_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       notEN;
    logic [7:0] Request;
    logic       Release;
    logic [7:0] Grant;
    logic [2:0] GrantIndex;
    logic       GrantValid;
    logic       Timeout;

    int n_total = 0;
    int n_bad   = 0;

    rr_resource_arbiter8 #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .notEN      (notEN),
        .Request    (Request),
        .Release    (Release),
        .Grant      (Grant),
        .GrantIndex (GrantIndex),
        .GrantValid (GrantValid),
        .Timeout    (Timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Model: who owns the resource, how many cycles it has held it, pending gap.
    int m_owner = -1;
    int m_age   = 0;
    int m_last  = 7;
    bit m_cool  = 1'b0;
    bit m_to    = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_owner <= -1;
            m_age   <= 0;
            m_last  <= 7;
            m_cool  <= 1'b0;
            m_to    <= 1'b0;
        end else begin : upd
            int o, a, l, w, st;
            bit c, t;
            o = m_owner; a = m_age; l = m_last; c = m_cool; t = 1'b0;
            if (o >= 0) begin
                a = a + 1;
                if (!Request[o] || Release || (TO != 0 && a == TO)) begin
                    t = (TO != 0 && a == TO) && Request[o] && !Release;
                    o = -1;
                    c = 1'b1;
                end
            end else if (c) begin
                c = 1'b0;
            end else if (!notEN && Request != 8'h00) begin
                st = RR ? (l + 1) % 8 : 0;
                w  = -1;
                for (int k = 0; k < 8; k++)
                    if (w < 0 && Request[(st + k) % 8]) w = (st + k) % 8;
                o = w; a = 0; l = w;
            end
            m_owner <= o;
            m_age   <= a;
            m_last  <= l;
            m_cool  <= c;
            m_to    <= t;
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            check("grant", 32'(Grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("grant_index", 32'(GrantIndex), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            check("grant_valid", 32'(GrantValid), 32'(m_owner >= 0));
            check("timeout", 32'(Timeout), 32'(m_to));
        end
    end

    initial begin
        RST = 1'b1; notEN = 1'b0; Request = 8'h00; Release = 1'b0;
        cyc(2);
        check("rst_grant", 32'(Grant), 32'h0);
        check("rst_valid", 32'(GrantValid), 32'h0);
        check("rst_timeout", 32'(Timeout), 32'h0);
        RST = 1'b0;

        // Lowest index wins, drop, then next requester after the gap.
        Request = 8'b0010_1100; cyc(1);
        check("t1_grant", 32'(Grant), 32'h04);
        check("t1_idx", 32'(GrantIndex), 32'd2);
        Request = 8'b0010_1000; cyc(1);
        check("t1_cooldown", 32'(Grant), 32'h0);
        cyc(2);
        check("t1_regrant", 32'(Grant), 32'h08);
        Request = 8'h00; cyc(2);

        // Release by owner 5, re-grant after two empty cycles.
        Request = 8'h20; cyc(1);
        check("t2_grant", 32'(Grant), 32'h20);
        check("t2_idx", 32'(GrantIndex), 32'd5);
        Release = 1'b1; cyc(1); Release = 1'b0;
        check("t2_released", 32'(Grant), 32'h0);
        cyc(1);
        check("t2_gap", 32'(Grant), 32'h0);
        cyc(1);
        check("t2_regrant", 32'(Grant), 32'h20);
        Request = 8'h00; cyc(2);

        // Timeout after exactly TO cycles, then release coinciding with the limit.
        Request = 8'h01;
        for (int c = 1; c <= TO; c++) begin
            cyc(1);
            check("t3_hold", 32'(Grant), 32'h01);
        end
        cyc(1);
        check("t3_revoked", 32'(Grant), 32'h0);
        check("t3_timeout", 32'(Timeout), 32'h1);
        cyc(1);
        check("t3_pulse_end", 32'(Timeout), 32'h0);
        cyc(1);
        check("t3_regrant", 32'(Grant), 32'h01);
        cyc(3);
        check("t3_last_cycle", 32'(Grant), 32'h01);
        Release = 1'b1; cyc(1); Release = 1'b0;
        check("t3_rel_grant", 32'(Grant), 32'h0);
        check("t3_rel_timeout", 32'(Timeout), 32'h0);
        Request = 8'h00; cyc(1);

        // notEN does not abort a grant, but blocks new ones; Release in idle ignored.
        Request = 8'h02; cyc(1);
        check("t4_grant", 32'(Grant), 32'h02);
        notEN = 1'b1; cyc(1);
        check("t4_hold_noten", 32'(Grant), 32'h02);
        Request = 8'h00; cyc(1);
        check("t4_drop", 32'(Grant), 32'h0);
        Request = 8'hFF; Release = 1'b1; cyc(1); Release = 1'b0;
        cyc(2);
        check("t4_blocked", 32'(Grant), 32'h0);
        notEN = 1'b0; cyc(1);
        check("t4_unblocked", 32'(Grant), RR ? 32'h04 : 32'h01);

        // Asynchronous reset in the middle of a grant.
        #2 RST = 1'b1; Request = 8'h80;
        #1;
        check("t5_async_grant", 32'(Grant), 32'h0);
        check("t5_async_idx", 32'(GrantIndex), 32'h0);
        check("t5_async_valid", 32'(GrantValid), 32'h0);
        check("t5_async_timeout", 32'(Timeout), 32'h0);
        cyc(1); RST = 1'b0;
        cyc(1);
        check("t5_grant", 32'(Grant), 32'h80);
        check("t5_idx", 32'(GrantIndex), 32'd7);

        // All requesting, each owner releases after one cycle.
        Request = 8'hFF; Release = 1'b1; cyc(1); Release = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cyc(2);
            check("t6_seq_idx", 32'(GrantIndex), RR ? 32'(k % 8) : 32'd0);
            Release = 1'b1; cyc(1); Release = 1'b0;
        end
        Request = 8'h00; cyc(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_resource_arbiter8.md
Name: rr_resource_arbiter8

Overview:
- Shares one downstream resource between 8 requesters.
- Grants exactly one requester at a time and holds the grant until the owner releases it, drops its request, or times out.
- Selection uses low-index-wins priority, with optional round-robin rotation.
- Sits in front of any shared datapath block that would otherwise need an external enable/select.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles a grant may be held. 0 disables the timeout.
- CNT_W, 5: width of the hold counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous reset, active-high
- notEN  input  1  high blocks new grants; does not abort a grant in progress
- Request  input  8  level request per requester; bit 0 is highest fixed priority
- Release  input  1  one-cycle pulse from the current owner ending its grant
- Grant  output  8  one-hot grant, registered
- GrantIndex  output  3  binary index of the owner; valid only while GrantValid=1
- GrantValid  output  1  high while any grant is active (equals |Grant)
- Timeout  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (async, RST=1): state=IDLE, Grant=0, GrantIndex=0, GrantValid=0, Timeout=0, hold counter=0, round-robin pointer Last=7. All outputs are registered.
- States: IDLE, GRANT, COOLDOWN.
- IDLE, exit condition: leave IDLE only when notEN=0 and |Request=1.
- IDLE, selection: the winner index i comes from the priority select.
- IDLE, next edge: state=GRANT, Grant=1<<i, GrantIndex=i, GrantValid=1, counter=0.
- IDLE, latency: a request sampled at edge k appears as Grant after edge k, i.e. 1 cycle.
- GRANT: counter increments each cycle, saturating.
- GRANT exits to COOLDOWN on the first of:
  - Request[i]=0;
  - Release=1;
  - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1.
- Grant duration: with no release or drop, Grant stays high exactly TIMEOUT_CYCLES cycles.
- Timeout-only exit: if the exit is caused only by timeout, Timeout=1 for the first COOLDOWN cycle.
- Simultaneous exit causes: when Release or a request drop coincides with the timeout condition, Timeout=0.
- GRANT exit outputs: Grant, GrantValid and GrantIndex clear to 0 on the exit edge.
- COOLDOWN: lasts one cycle with no grant, then returns to IDLE. The minimum gap between two grants is 2 idle cycles (COOLDOWN, then IDLE arbitration).
- notEN=1 in GRANT: the current grant continues normally. notEN=1 in IDLE: stays in IDLE.
- Requests other than the owner's are ignored during GRANT and COOLDOWN. There is no queuing; requesters hold their levels.
- Release in IDLE or COOLDOWN is ignored.
- RST asserted mid-grant: immediate return to reset values with no Timeout pulse.

Optional Feature:
- Macro: RR_RESOURCE_ARBITER8_ROUND_ROBIN_EN.
- Defined (round robin):
  - Priority order starts at (Last+1) mod 8 and wraps through 7 back to 0.
  - Last updates to i on each grant.
  - Implementation: rotate Request right by Last+1, fixed-priority encode, add Last+1 mod 8.
- Undefined (fixed priority): the lowest set Request index always wins, and the Last register is not built.

Decomposition:
- Package rr_arb_pkg:
  - NUM_REQ=8, IDX_W=3;
  - state enum {IDLE, GRANT, COOLDOWN};
  - rotate function.
- Sub-module prio_enc8_lowfirst: combinational, 8-bit in → 3-bit index plus a Found flag, lowest set bit wins. One instance sits in the select path.

Test Plan:
- Fixed priority: Request=8'b0010_1100 from idle → Grant=8'b0000_0100, GrantIndex=2 one cycle later. Drop Request[2] → COOLDOWN. Next grant is Grant=8'b0000_1000.
- Release: owner index 5 pulses Release while Request[5] stays 1 → Grant=0 next edge. Re-grant to 5 after 2 idle cycles if it is still the only requester.
- Timeout: TIMEOUT_CYCLES=4, Request=8'h01 held → Grant high exactly 4 cycles, Timeout=1 for one cycle, then re-grant. Repeat with Release coinciding on the 4th cycle → Timeout=0.
- notEN: assert notEN=1 mid-grant → grant completes normally. Request=8'hFF with notEN=1 in IDLE → no grant until notEN=0.
- Round robin (macro defined): Request=8'hFF, each owner releases after 1 cycle → grant sequence 0,1,2,...,7,0. Without the macro → 0,0,0,...
- Reset: assert RST mid-GRANT asynchronously → all outputs 0 before the next CLK edge. After deassertion the first grant with Request=8'h80 goes to index 7.
